// File: rtl/packet_build_engine_if.sv
// ----------------------------------------------------------------------------
// packet_build_engine_if
// Purpose : bundles the read channel (input memory -> engine) and the write
//           channel (engine -> output memory) used by packet_build_engine.
// Signals : rdata/rvalid/rlast/rready  read data beat handshake
//           wdata/wvalid/wlast/wready  write data beat handshake
// Modports: master - the packet engine (drives rready and the write beat)
//           slave  - the memory side / environment
// ----------------------------------------------------------------------------
interface packet_build_engine_if;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wlast;
  logic        wready;

  modport master (
    input  rdata, rvalid, rlast, wready,
    output rready, wdata, wvalid, wlast
  );

  modport slave (
    output rdata, rvalid, rlast, wready,
    input  rready, wdata, wvalid, wlast
  );
endinterface

// File: rtl/packet_build_engine.sv
// ----------------------------------------------------------------------------
// packet_build_engine
// Purpose : per accepted start, reads NW 32-bit words, extracts the payload
//           bytes of the selected lanes, prepends a 2-byte header
//           ({data_sel, byte_cnt}, hdr_id), optionally appends a CRC8 of the
//           payload, and writes the packet out as 32-bit words. Output byte
//           k+2 always carries payload byte k.
// Config  : define CRC_APPEND_EN to append the CRC8 byte (poly CRC_POLY,
//           init 0, MSB-first, no reflection, no final XOR). Without it the
//           CRC state and logic are absent.
// Ports   : clk       clock
//           reset     asynchronous active-low reset
//           start     one-cycle request, sampled only in IDLE
//           byte_cnt  address of the last input byte (0..15)
//           data_sel  lane mode: 0 lane0, 1 lanes 0-1, others all lanes
//           hdr_id    header byte 1
//           busy      high from accepted start until done
//           done      one-cycle pulse after the final write handshake
//           err       sticky rlast mismatch flag, cleared on next start
//           bus       read/write channels (master modport)
// ----------------------------------------------------------------------------
module packet_build_engine #(
  parameter int          MAX_WORDS = 4,
  parameter logic [7:0]  CRC_POLY  = 8'h07
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 byte_cnt,
  input  logic [3:0]                 data_sel,
  input  logic [7:0]                 hdr_id,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  packet_build_engine_if.master      bus
);

  localparam int PAY_BYTES = MAX_WORDS * 4;

`ifdef CRC_APPEND_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CRC, S_WRITE, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
`endif

  state_t      r_state;
  logic [3:0]  r_bc;
  logic [3:0]  r_ds;
  logic [7:0]  r_hdr;
  logic [1:0]  r_mode;
  logic [1:0]  r_beat;
  logic [7:0]  r_pay [PAY_BYTES];
  logic [2:0]  r_widx;
  logic        r_rready;
  logic        r_wvalid;
  logic        r_wlast;
  logic [31:0] r_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
`ifdef CRC_APPEND_EN
  logic [7:0]  r_crc;
  logic [3:0]  r_cidx;
`endif

  logic [1:0]  w_nw_m1;
  logic [4:0]  w_len;
  logic [4:0]  w_total;
  logic [2:0]  w_nwords;
  logic [2:0]  w_widx_nxt;
  logic [31:0] w_word;

`ifdef CRC_APPEND_EN
  function automatic logic [7:0] crc8_update(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v;
    v = c ^ d;
    for (int i = 0; i < 8; i++) begin
      v = v[7] ? ({v[6:0], 1'b0} ^ CRC_POLY) : {v[6:0], 1'b0};
    end
    return v;
  endfunction
`endif

  // Byte n of the assembled output stream: header, payload, [CRC], zero pad.
  // The payload index n-2 is taken modulo 16, which is exact for n in 2..17.
  function automatic logic [7:0] out_byte(input logic [4:0] n);
    if (n == 5'd0)
      return {r_ds, r_bc};
    else if (n == 5'd1)
      return r_hdr;
    else if (n < w_len + 5'd2)
      return r_pay[n[3:0] - 4'd2];
`ifdef CRC_APPEND_EN
    else if (n == w_len + 5'd2)
      return r_crc;
`endif
    else
      return 8'h00;
  endfunction

  assign w_nw_m1 = r_bc[3:2];

  always_comb begin
    w_len = 5'd0;
    case (r_mode)
      2'd0:    w_len = {3'b000, r_bc[3:2]} + 5'd1;
      2'd1:    w_len = {2'b00, r_bc[3:2], 1'b0} + {4'b0000, (r_bc[1:0] != 2'b00)} + 5'd1;
      default: w_len = {1'b0, r_bc} + 5'd1;
    endcase
  end

`ifdef CRC_APPEND_EN
  assign w_total = w_len + 5'd3;
`else
  assign w_total = w_len + 5'd2;
`endif

  assign w_nwords   = 3'((w_total + 5'd3) >> 2);
  // Word to load next: word 0 on the first WRITE cycle, else the successor.
  assign w_widx_nxt = r_wvalid ? (r_widx + 3'd1) : 3'd0;

  always_comb begin
    w_word = {out_byte({w_widx_nxt, 2'd3}), out_byte({w_widx_nxt, 2'd2}),
              out_byte({w_widx_nxt, 2'd1}), out_byte({w_widx_nxt, 2'd0})};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_bc     <= '0;
      r_ds     <= '0;
      r_hdr    <= '0;
      r_mode   <= '0;
      r_beat   <= '0;
      r_widx   <= '0;
      r_rready <= 1'b0;
      r_wvalid <= 1'b0;
      r_wlast  <= 1'b0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < PAY_BYTES; i++) r_pay[i] <= '0;
`ifdef CRC_APPEND_EN
      r_crc    <= '0;
      r_cidx   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bc     <= byte_cnt;
            r_ds     <= data_sel;
            r_hdr    <= hdr_id;
            r_mode   <= (data_sel == 4'd0) ? 2'd0 : (data_sel == 4'd1) ? 2'd1 : 2'd2;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_rready <= 1'b1;
            r_beat   <= '0;
            r_widx   <= '0;
`ifdef CRC_APPEND_EN
            r_crc    <= '0;
            r_cidx   <= '0;
`endif
            r_state  <= S_READ;
          end
        end

        S_READ: begin
          if (bus.rvalid && r_rready) begin
            case (r_mode)
              2'd0: r_pay[{2'b00, r_beat}] <= bus.rdata[7:0];
              2'd1: begin
                r_pay[{1'b0, r_beat, 1'b0}] <= bus.rdata[7:0];
                r_pay[{1'b0, r_beat, 1'b1}] <= bus.rdata[15:8];
              end
              default: begin
                r_pay[{r_beat, 2'd0}] <= bus.rdata[7:0];
                r_pay[{r_beat, 2'd1}] <= bus.rdata[15:8];
                r_pay[{r_beat, 2'd2}] <= bus.rdata[23:16];
                r_pay[{r_beat, 2'd3}] <= bus.rdata[31:24];
              end
            endcase
            // rlast is only checked, never used to end the read
            if (bus.rlast != (r_beat == w_nw_m1)) r_err <= 1'b1;
            if (r_beat == w_nw_m1) begin
              r_rready <= 1'b0;
`ifdef CRC_APPEND_EN
              r_state  <= S_CRC;
`else
              r_state  <= S_WRITE;
`endif
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end
        end

`ifdef CRC_APPEND_EN
        S_CRC: begin
          r_crc  <= crc8_update(r_crc, r_pay[r_cidx]);
          r_cidx <= r_cidx + 4'd1;
          if ({1'b0, r_cidx} == w_len - 5'd1) r_state <= S_WRITE;
        end
`endif

        S_WRITE: begin
          if (!r_wvalid) begin
            r_wvalid <= 1'b1;
            r_wdata  <= w_word;
            r_widx   <= 3'd0;
            r_wlast  <= (w_nwords == 3'd1);
          end else if (bus.wready) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_widx   <= r_widx + 3'd1;
              r_wdata  <= w_word;
              r_wlast  <= ((r_widx + 3'd2) == w_nwords);
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rready = r_rready;
  assign bus.wvalid = r_wvalid;
  assign bus.wlast  = r_wlast;
  assign bus.wdata  = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_packet_build_engine.sv
module tb_packet_build_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] byte_cnt;
  logic [3:0] data_sel;
  logic [7:0] hdr_id;
  logic       busy, done, err;

  packet_build_engine_if bus();

  packet_build_engine dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .byte_cnt (byte_cnt),
    .data_sel (data_sel),
    .hdr_id   (hdr_id),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] in_words [0:3];
  logic [31:0] exp_q [$];
  logic        exp_l_q [$];
  logic [31:0] got_q [$];
  logic        got_l_q [$];
  int          exp_lat;
  logic [7:0]  exp_crc;
  int          beats, stall_bad, done_cnt, lat, timeout;
  logic        rready_at1;

  // Reference model: walk input addresses, keep bytes of the lanes in use,
  // build the byte stream and pack it into words.
  task automatic push_expected(input logic [3:0] bc, input logic [3:0] ds, input logic [7:0] hdr);
    logic [7:0]  ob [$];
    logic [7:0]  crc;
    logic [31:0] word;
    int          L, nwo;
    ob.push_back({ds, bc});
    ob.push_back(hdr);
    crc = 8'h00;
    L = 0;
    for (int a = 0; a <= int'(bc); a++) begin
      int   lane;
      bit   use_it;
      logic [7:0] b;
      lane = a % 4;
      use_it = (ds == 4'd0) ? (lane == 0) : (ds == 4'd1) ? (lane < 2) : 1'b1;
      if (use_it) begin
        b = in_words[a / 4][8 * lane +: 8];
        ob.push_back(b);
        L++;
        for (int i = 7; i >= 0; i--) begin
          logic fb;
          fb  = crc[7] ^ b[i];
          crc = {crc[6:0], 1'b0};
          if (fb) crc = crc ^ 8'h07;
        end
      end
    end
`ifdef CRC_APPEND_EN
    ob.push_back(crc);
`endif
    exp_crc = crc;
    nwo = (ob.size() + 3) / 4;
    for (int w = 0; w < nwo; w++) begin
      word = '0;
      for (int l = 0; l < 4; l++)
        if (4 * w + l < ob.size()) word[8 * l +: 8] = ob[4 * w + l];
      exp_q.push_back(word);
      exp_l_q.push_back(w == nwo - 1);
    end
    exp_lat = int'(bc) / 4 + 1 + nwo + 2;
`ifdef CRC_APPEND_EN
    exp_lat += L;
`endif
  endtask

  // wmode: 0 = wready always 1, 1 = random, 2 = held low for 40 wvalid cycles
  task automatic run_packet(input logic [3:0] bc, input logic [3:0] ds, input logic [7:0] hdr,
                            input int rlast_beat, input int wmode);
    int          nw, cyc, wv;
    logic [31:0] held;
    logic        held_l, stalled;
    got_q.delete(); got_l_q.delete();
    beats = 0; stall_bad = 0; done_cnt = 0; lat = -1; timeout = 0;
    stalled = 1'b0; wv = 0; held = '0; held_l = 1'b0; rready_at1 = 1'b0;
    nw = int'(bc) / 4 + 1;
    @(negedge clk);
    byte_cnt = bc; data_sel = ds; hdr_id = hdr; start = 1'b1;
    push_expected(bc, ds, hdr);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (cyc == 1) rready_at1 = bus.rready;
      if (beats < nw) begin
        bus.rvalid = 1'b1; bus.rdata = in_words[beats]; bus.rlast = (beats == rlast_beat);
      end else begin
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
      end
      case (wmode)
        0:       bus.wready = 1'b1;
        1:       bus.wready = 1'($urandom_range(0, 1));
        default: bus.wready = (wv >= 40);
      endcase
      if (stalled && (!bus.wvalid || bus.wdata !== held || bus.wlast !== held_l)) stall_bad++;
      if (bus.wvalid) wv++;
      if (bus.wvalid && bus.wready) begin
        got_q.push_back(bus.wdata); got_l_q.push_back(bus.wlast); stalled = 1'b0;
      end else if (bus.wvalid) begin
        stalled = 1'b1; held = bus.wdata; held_l = bus.wlast;
      end else begin
        stalled = 1'b0;
      end
      if (bus.rvalid && bus.rready) beats++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = cyc;
      end
      if (lat >= 0 && cyc >= lat + 3) break;
      @(negedge clk);
      cyc++;
    end
    if (lat < 0) timeout = 1;
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.wready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; byte_cnt = '0; data_sel = '0; hdr_id = '0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0; bus.wready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b want=0", bus.rready); end
    total++; if (bus.wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid got=%b want=0", bus.wvalid); end
    total++; if (bus.wlast !== 1'b0) begin bad++; $display("FAIL reset_wlast got=%b want=0", bus.wlast); end
    total++; if (bus.wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_op2_basic;
    logic [31:0] e, g;
    logic        el, gl;
    int          idx;
    in_words[0] = 32'h44332211;
    run_packet(4'd3, 4'd2, 8'hA5, 0, 0);
    total++; if (timeout != 0) begin bad++; $display("FAIL op2_timeout got=%0d want=0", timeout); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL op2_words got=%0d want=%0d", got_q.size(), exp_q.size()); end
    total++; if (got_q.size() > 0 && got_q[0] !== 32'h2211A523) begin bad++; $display("FAIL op2_word0_const got=%h want=2211a523", got_q[0]); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); el = exp_l_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      gl = (got_l_q.size() > 0) ? got_l_q.pop_front() : 1'bx;
      total++; if (g !== e) begin bad++; $display("FAIL op2_wdata[%0d] got=%h want=%h", idx, g, e); end
      total++; if (gl !== el) begin bad++; $display("FAIL op2_wlast[%0d] got=%b want=%b", idx, gl, el); end
      idx++;
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL op2_done_pulses got=%0d want=1", done_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL op2_err got=%b want=0", err); end
    total++; if (lat != exp_lat) begin bad++; $display("FAIL op2_latency got=%0d want=%0d", lat, exp_lat); end
    total++; if (rready_at1 !== 1'b1) begin bad++; $display("FAIL op2_rready_rise got=%b want=1", rready_at1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL op2_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_op0_single;
    logic [31:0] e, g;
    in_words[0] = 32'hDDCCBB11;
    run_packet(4'd0, 4'd0, 8'h3C, 0, 0);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL op0_words got=%0d want=1", got_q.size()); end
    total++; if (got_q.size() > 0 && got_q[0][23:0] !== 24'h113C00) begin bad++; $display("FAIL op0_low_const got=%h want=113c00", got_q[0][23:0]); end
    total++; if (got_l_q.size() > 0 && got_l_q[0] !== 1'b1) begin bad++; $display("FAIL op0_wlast got=%b want=1", got_l_q[0]); end
    e = exp_q.pop_front(); void'(exp_l_q.pop_front());
    g = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
    total++; if (g !== e) begin bad++; $display("FAIL op0_wdata got=%h want=%h", g, e); end
    total++; if (lat != exp_lat) begin bad++; $display("FAIL op0_latency got=%0d want=%0d", lat, exp_lat); end
    exp_q.delete(); exp_l_q.delete();
  endtask

  task automatic test_op1;
    logic [31:0] e, g;
    int          idx;
    in_words[0] = 32'h44332211;
    in_words[1] = 32'h88776655;
    run_packet(4'd5, 4'd1, 8'h7E, 1, 0);
    total++; if (got_q.size() > 0 && {got_q[0][31:16], got_q[0][7:0]} !== 24'h221115) begin bad++; $display("FAIL op1_word0_const got=%h want=2211xx15", got_q[0]); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL op1_words got=%0d want=%0d", got_q.size(), exp_q.size()); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_l_q.pop_front());
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      total++; if (g !== e) begin bad++; $display("FAIL op1_wdata[%0d] got=%h want=%h", idx, g, e); end
      idx++;
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL op1_err got=%b want=0", err); end
  endtask

  task automatic test_stall;
    logic [31:0] e, g, lastw;
    logic        el, gl;
    int          idx;
    in_words[0] = 32'h44332211; in_words[1] = 32'h88776655;
    in_words[2] = 32'hCCBBAA99; in_words[3] = 32'h00FFEEDD;
    run_packet(4'd15, 4'd2, 8'h5A, 3, 1);
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL stall_words got=%0d want=5", got_q.size()); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stall_bad); end
    lastw = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 32'hxxxxxxxx;
`ifdef CRC_APPEND_EN
    total++; if (lastw[23:16] !== exp_crc) begin bad++; $display("FAIL stall_crc_byte got=%h want=%h", lastw[23:16], exp_crc); end
`else
    total++; if (lastw[31:16] !== 16'h0000) begin bad++; $display("FAIL stall_pad got=%h want=0000", lastw[31:16]); end
`endif
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); el = exp_l_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      gl = (got_l_q.size() > 0) ? got_l_q.pop_front() : 1'bx;
      total++; if (g !== e) begin bad++; $display("FAIL stall_wdata[%0d] got=%h want=%h", idx, g, e); end
      total++; if (gl !== el) begin bad++; $display("FAIL stall_wlast[%0d] got=%b want=%b", idx, gl, el); end
      idx++;
    end
    // wready held low for a long time; data_sel 11 behaves as all lanes
    run_packet(4'd6, 4'd11, 8'hC3, 1, 2);
    total++; if (timeout != 0) begin bad++; $display("FAIL hold_timeout got=%0d want=0", timeout); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL hold_stable got=%0d want=0", stall_bad); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_l_q.pop_front());
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      total++; if (g !== e) begin bad++; $display("FAIL hold_wdata[%0d] got=%h want=%h", idx, g, e); end
      idx++;
    end
  endtask

  task automatic test_rlast_err;
    logic [31:0] e, g;
    int          idx;
    in_words[0] = 32'h04030201; in_words[1] = 32'h08070605;
    run_packet(4'd7, 4'd0, 8'h11, 0, 0);
    total++; if (beats != 2) begin bad++; $display("FAIL rlast_beats got=%0d want=2", beats); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rlast_err got=%b want=1", err); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_l_q.pop_front());
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      total++; if (g !== e) begin bad++; $display("FAIL rlast_wdata[%0d] got=%h want=%h", idx, g, e); end
      idx++;
    end
    repeat (5) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rlast_err_sticky got=%b want=1", err); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e, g;
    int          idx;
    in_words[0] = 32'h5566A7B8;
    run_packet(4'd2, 4'd1, 8'h22, 0, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err_cleared got=%b want=0", err); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_l_q.pop_front());
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      total++; if (g !== e) begin bad++; $display("FAIL b2b_wdata[%0d] got=%h want=%h", idx, g, e); end
      idx++;
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e, g;
    int          idx, hs, rb, cyc, dseen;
    logic        hit;
    in_words[0] = 32'h13121110; in_words[1] = 32'h17161514;
    in_words[2] = 32'h1B1A1918; in_words[3] = 32'h1F1E1D1C;
    @(negedge clk);
    byte_cnt = 4'd15; data_sel = 4'd2; hdr_id = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0; rb = 0; hit = 1'b0; dseen = 0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (done) dseen++;
      if (hs == 1 && bus.wvalid) begin hit = 1'b1; break; end
      bus.rvalid = (rb < 4); bus.rdata = in_words[rb % 4]; bus.rlast = (rb == 3);
      bus.wready = 1'b1;
      if (bus.wvalid && bus.wready) hs++;
      if (bus.rvalid && bus.rready) rb++;
      @(negedge clk);
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rstmid_reach_word1 got=%b want=1", hit); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.wvalid !== 1'b0) begin bad++; $display("FAIL rstmid_wvalid got=%b want=0", bus.wvalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.wready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ((done | dseen != 0) !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b seen=%0d want=0", done, dseen); end
    rst_n = 1'b1;
    @(negedge clk);
    run_packet(4'd15, 4'd2, 8'h99, 3, 0);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_words got=%0d want=%0d", got_q.size(), exp_q.size()); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_l_q.pop_front());
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      total++; if (g !== e) begin bad++; $display("FAIL rstmid_wdata[%0d] got=%h want=%h", idx, g, e); end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_op2_basic();
    test_op0_single();
    test_op1();
    test_stall();
    test_rlast_err();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "global timeout");
  end
endmodule
